rfdp_fifo_ctrl: RTL and testbench



---
 rtl/rfdp_fifo_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rfdp_fifo_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfdp_fifo_ctrl.sv
// rfdp_fifo_ctrl: single-clock FIFO controller around one rfdp dual-port
// register-file macro used as a circular buffer. Port B of the macro is
// write-only and port A is read-only, with a registered address and an
// unregistered Q. The one-cycle read latency is hidden behind a 2-entry
// output buffer, so one word per cycle can flow in and out.
//
// Handshake semantics (both sides): a transfer happens at a rising edge
// exactly when valid and ready are both 1 during the preceding cycle. The
// producer holds data stable while valid is high and not yet accepted.
// s_ready depends only on internal state and on rst_n/flush, never on
// s_valid. m_valid depends only on internal state and rst_n, never on m_ready.
module rfdp_fifo_ctrl #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 36,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 3)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [CW-1:0]    count,
   output logic [AW-1:0]    ram_ab,
   output logic [WIDTH-1:0] ram_db,
   output logic             ram_cenb,
   output logic [AW-1:0]    ram_aa,
   output logic             ram_cena,
   input  logic [WIDTH-1:0] ram_qa
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [CW-1:0] RAM_FULL  = CW'(DEPTH);

   // Circular-buffer pointers into the macro.
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   // Words written to the macro at earlier edges and not yet read out.
   // Because a word only becomes readable one edge after its write, the
   // read port never addresses the word being written in the same cycle.
   logic [CW-1:0]    ram_cnt;
   // A read was issued last cycle; ram_qa carries its data this cycle.
   logic             inflight;
   // Output buffer: obuf0 is the head presented on m_data.
   logic [WIDTH-1:0] obuf0;
   logic [WIDTH-1:0] obuf1;
   logic [1:0]       obuf_cnt;
   // Registered total occupancy (macro + in-flight + output buffer).
   logic [CW-1:0]    count_q;

   // Next-state values.
   logic [AW-1:0]    wptr_n;
   logic [AW-1:0]    rptr_n;
   logic [CW-1:0]    ram_cnt_n;
   logic             inflight_n;
   logic [WIDTH-1:0] obuf0_n;
   logic [WIDTH-1:0] obuf1_n;
   logic [1:0]       obuf_cnt_n;
   logic [CW-1:0]    count_n;

   // Handshake and read-issue decisions.
   logic             wr_fire;
   logic             pop;
   logic             issue;
   logic [2:0]       obuf_need;
   logic [2:0]       obuf_room;

   // Advance a pointer with wrap at the last macro word (DEPTH need not be
   // a power of two, so the wrap is explicit).
   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == LAST_ADDR) ? '0 : p + AW'(1);
   endfunction

   // Stream-side handshakes and the read-issue rule. A read may be issued
   // only if, after this cycle's pop, the output buffer plus the read
   // already in flight leaves a free slot for the new word.
   always_comb begin
      s_ready   = rst_n & ~flush & (ram_cnt < RAM_FULL);
      m_valid   = rst_n & (obuf_cnt != 2'd0);
      m_data    = obuf0;
      wr_fire   = s_valid & s_ready;
      pop       = m_valid & m_ready;
      obuf_need = 3'(obuf_cnt) + 3'(inflight);
      obuf_room = 3'd2 + 3'(pop);
      issue     = rst_n & ~flush & (ram_cnt != '0) & (obuf_need < obuf_room);
   end

   // Macro port drive: enables are active-low; address/data are parked at
   // zero whenever the port is idle so the macro inputs are quiet.
   always_comb begin
      ram_cenb = ~wr_fire;
      ram_ab   = wr_fire ? wptr : '0;
      ram_db   = wr_fire ? s_data : '0;
      ram_cena = ~issue;
      ram_aa   = issue ? rptr : '0;
      count    = rst_n ? count_q : '0;
   end

   // Next-state: pointer/count updates, output-buffer shift on pop, then
   // capture of the in-flight read data into the (post-shift) tail.
   always_comb begin
      wptr_n     = wptr;
      rptr_n     = rptr;
      ram_cnt_n  = ram_cnt;
      inflight_n = issue;
      obuf0_n    = obuf0;
      obuf1_n    = obuf1;
      obuf_cnt_n = obuf_cnt;

      if (wr_fire) begin
         wptr_n = bump(wptr);
      end
      if (issue) begin
         rptr_n = bump(rptr);
      end
      // Simultaneous write and issue leaves ram_cnt unchanged.
      ram_cnt_n = ram_cnt + CW'(wr_fire) - CW'(issue);

      if (pop) begin
         obuf0_n    = obuf1;
         obuf_cnt_n = obuf_cnt - 2'd1;
      end
      if (inflight) begin
         if (obuf_cnt_n == 2'd0) begin
            obuf0_n = ram_qa;
         end else begin
            obuf1_n = ram_qa;
         end
         obuf_cnt_n = obuf_cnt_n + 2'd1;
      end

      count_n = ram_cnt_n + CW'(inflight_n) + CW'(obuf_cnt_n);
   end

   // State register: reset clears everything, flush drops all contents
   // (including a read in flight) but leaves stale obuf data in place.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
         obuf0    <= '0;
         obuf1    <= '0;
         obuf_cnt <= 2'd0;
         count_q  <= '0;
      end else if (flush) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
         obuf_cnt <= 2'd0;
         count_q  <= '0;
      end else begin
         wptr     <= wptr_n;
         rptr     <= rptr_n;
         ram_cnt  <= ram_cnt_n;
         inflight <= inflight_n;
         obuf0    <= obuf0_n;
         obuf1    <= obuf1_n;
         obuf_cnt <= obuf_cnt_n;
         count_q  <= count_n;
      end
   end

endmodule

// File: tb/tb_rfdp_fifo_ctrl.sv
// Directed bench for rfdp_fifo_ctrl: one DEPTH=8 instance for the main
// scenarios and one DEPTH=12 instance for non-power-of-two wrap. Each
// instance has a behavioural macro model (write port B, read port A with
// one-cycle latency) and a scoreboard queue of accepted words.
module tb_rfdp_fifo_ctrl;

   localparam int W = 16;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;
   logic flush;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DEPTH=8 instance ----------------
   logic          s_valid8, s_ready8, m_valid8, m_ready8;
   logic [W-1:0]  s_data8, m_data8;
   logic [3:0]    count8;
   logic [2:0]    ab8, aa8;
   logic [W-1:0]  db8, qa8;
   logic          cenb8, cena8;
   logic [W-1:0]  mem8 [0:7];

   rfdp_fifo_ctrl #(.DEPTH(8), .WIDTH(W)) u8 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8),
      .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8),
      .count(count8),
      .ram_ab(ab8), .ram_db(db8), .ram_cenb(cenb8),
      .ram_aa(aa8), .ram_cena(cena8), .ram_qa(qa8)
   );

   always @(posedge clk) begin
      if (!cenb8) mem8[ab8] <= db8;
      if (!cena8) qa8 <= mem8[aa8];
   end

   // ---------------- DEPTH=12 instance ----------------
   logic          s_valid12, s_ready12, m_valid12, m_ready12;
   logic [W-1:0]  s_data12, m_data12;
   logic [3:0]    count12;
   logic [3:0]    ab12, aa12;
   logic [W-1:0]  db12, qa12;
   logic          cenb12, cena12;
   logic [W-1:0]  mem12 [0:11];

   rfdp_fifo_ctrl #(.DEPTH(12), .WIDTH(W)) u12 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .s_valid(s_valid12), .s_ready(s_ready12), .s_data(s_data12),
      .m_valid(m_valid12), .m_ready(m_ready12), .m_data(m_data12),
      .count(count12),
      .ram_ab(ab12), .ram_db(db12), .ram_cenb(cenb12),
      .ram_aa(aa12), .ram_cena(cena12), .ram_qa(qa12)
   );

   always @(posedge clk) begin
      if (!cenb12 && ab12 < 4'd12) mem12[ab12] <= db12;
      if (!cena12 && aa12 < 4'd12) qa12 <= mem12[aa12];
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp8_q[$];
   logic [W-1:0] exp12_q[$];
   int popped12 = 0;
   int range_bad12 = 0;
   logic wrap_ab12 = 1'b0;
   logic wrap_aa12 = 1'b0;
   logic [3:0] last_ab12 = 4'd0;
   logic [3:0] last_aa12 = 4'd0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
      end
   endtask

   // Sample both output streams mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n || flush) begin
         exp8_q.delete();
         exp12_q.delete();
      end else begin
         if (m_valid8 && m_ready8) begin
            total++;
            assert (exp8_q.size() != 0) else begin
               bad++;
               $error("FAIL pop8_empty obs=%0h exp=none", m_data8);
            end
            if (exp8_q.size() != 0) chk("data8", 64'(m_data8), 64'(exp8_q.pop_front()));
         end
         if (s_valid8 && s_ready8) exp8_q.push_back(s_data8);

         if (m_valid12 && m_ready12) begin
            total++;
            assert (exp12_q.size() != 0) else begin
               bad++;
               $error("FAIL pop12_empty obs=%0h exp=none", m_data12);
            end
            if (exp12_q.size() != 0) chk("data12", 64'(m_data12), 64'(exp12_q.pop_front()));
            popped12++;
         end
         if (s_valid12 && s_ready12) exp12_q.push_back(s_data12);

         if (!cenb12) begin
            if (ab12 > 4'd11) range_bad12++;
            if (last_ab12 == 4'd11 && ab12 == 4'd0) wrap_ab12 = 1'b1;
            last_ab12 = ab12;
         end
         if (!cena12) begin
            if (aa12 > 4'd11) range_bad12++;
            if (last_aa12 == 4'd11 && aa12 == 4'd0) wrap_aa12 = 1'b1;
            last_aa12 = aa12;
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_s_ready"}, 64'(s_ready8), 64'(0));
      chk({tag, "_m_valid"}, 64'(m_valid8), 64'(0));
      chk({tag, "_count"},   64'(count8),   64'(0));
      chk({tag, "_cenb"},    64'(cenb8),    64'(1));
      chk({tag, "_cena"},    64'(cena8),    64'(1));
      chk({tag, "_ab"},      64'(ab8),      64'(0));
      chk({tag, "_aa"},      64'(aa8),      64'(0));
      chk({tag, "_db"},      64'(db8),      64'(0));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int acc;
      int pushed12;
      rst_n = 1'b0; flush = 1'b0;
      s_valid8 = 1'b0; m_ready8 = 1'b0; s_data8 = '0;
      s_valid12 = 1'b0; m_ready12 = 1'b0; s_data12 = '0;

      // Reset: outputs held at their idle values while rst_n is low.
      step();
      step();
      s_valid8 = 1'b1; s_data8 = 16'h0777;
      #1;
      chk_reset_outputs("rst");

      // Single word: write 0x1A5 in cycle 0, m_valid in cycle 3.
      step();
      rst_n = 1'b1; s_valid8 = 1'b1; s_data8 = 16'h01A5; m_ready8 = 1'b1;
      #1;
      chk("sw_s_ready_c0", 64'(s_ready8), 64'(1));
      chk("sw_cenb_c0",    64'(cenb8),    64'(0));
      chk("sw_ab_c0",      64'(ab8),      64'(0));
      chk("sw_db_c0",      64'(db8),      64'(16'h01A5));
      step(); s_valid8 = 1'b0; #1;
      chk("sw_cena_c1",    64'(cena8),    64'(0));
      chk("sw_aa_c1",      64'(aa8),      64'(0));
      chk("sw_count_c1",   64'(count8),   64'(1));
      step(); #1;
      chk("sw_m_valid_c2", 64'(m_valid8), 64'(0));
      step(); #1;
      chk("sw_m_valid_c3", 64'(m_valid8), 64'(1));
      chk("sw_m_data_c3",  64'(m_data8),  64'(16'h01A5));
      step(); #1;
      chk("sw_count_c4",   64'(count8),   64'(0));
      chk("sw_m_valid_c4", 64'(m_valid8), 64'(0));

      // Fill: m_ready=0, data 1..20 offered; DEPTH+2 = 10 accepted.
      m_ready8 = 1'b0;
      acc = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         s_valid8 = 1'b1; s_data8 = 16'(i);
         #1;
         if (s_ready8) acc++;
      end
      step(); s_valid8 = 1'b0; #1;
      chk("fill_accepted", 64'(acc),      64'(10));
      chk("fill_s_ready",  64'(s_ready8), 64'(0));
      chk("fill_count",    64'(count8),   64'(10));
      m_ready8 = 1'b1;
      #1;
      for (int k = 1; k <= 10; k++) begin
         chk("drain_m_valid", 64'(m_valid8), 64'(1));
         chk("drain_m_data",  64'(m_data8),  64'(k));
         step();
      end
      chk("drain_count",   64'(count8),   64'(0));
      chk("drain_m_valid_end", 64'(m_valid8), 64'(0));

      // Streaming: 1 word/cycle; after the fill, m_valid stays high and
      // occupancy sits at 3 (one in macro, one in flight, one buffered).
      for (int c = 0; c < 1000; c++) begin
         step();
         s_valid8 = 1'b1; s_data8 = 16'(c + 256); m_ready8 = 1'b1;
         #1;
         if (c >= 3) begin
            chk("stream_m_valid", 64'(m_valid8), 64'(1));
            chk("stream_count",   64'(count8),   64'(3));
         end
      end
      step(); s_valid8 = 1'b0;
      for (int c = 0; c < 6; c++) step();
      chk("stream_end_count", 64'(count8), 64'(0));
      chk("stream_end_queue", 64'(exp8_q.size()), 64'(0));

      // Backpressure: m_ready toggles 1010... while writing continuously.
      for (int c = 0; c < 40; c++) begin
         step();
         s_valid8 = 1'b1; s_data8 = 16'(16'h2000 + c); m_ready8 = ~c[0];
      end
      step(); s_valid8 = 1'b0; m_ready8 = 1'b1;
      for (int c = 0; c < 20; c++) step();
      chk("bp_count", 64'(count8), 64'(0));
      chk("bp_queue", 64'(exp8_q.size()), 64'(0));

      // Flush with 5 words held and a read in flight.
      m_ready8 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         s_valid8 = 1'b1; s_data8 = 16'(16'h0300 + i);
      end
      step(); s_valid8 = 1'b0;
      for (int c = 0; c < 4; c++) step();
      chk("fl_count6", 64'(count8), 64'(6));
      m_ready8 = 1'b1;
      step(); m_ready8 = 1'b0; #1;
      chk("fl_count5", 64'(count8), 64'(5));
      flush = 1'b1; s_valid8 = 1'b1; s_data8 = 16'h0055; m_ready8 = 1'b1;
      #1;
      chk("fl_s_ready", 64'(s_ready8), 64'(0));
      chk("fl_m_valid", 64'(m_valid8), 64'(1));
      chk("fl_cena",    64'(cena8),    64'(1));
      chk("fl_cenb",    64'(cenb8),    64'(1));
      step();
      flush = 1'b0; s_valid8 = 1'b1; s_data8 = 16'h003C; m_ready8 = 1'b1;
      #1;
      chk("fl_after_m_valid", 64'(m_valid8), 64'(0));
      chk("fl_after_count",   64'(count8),   64'(0));
      chk("fl_after_s_ready", 64'(s_ready8), 64'(1));
      step(); s_valid8 = 1'b0; #1;
      chk("fl_c1_m_valid", 64'(m_valid8), 64'(0));
      step(); #1;
      chk("fl_c2_m_valid", 64'(m_valid8), 64'(0));
      step(); #1;
      chk("fl_c3_m_valid", 64'(m_valid8), 64'(1));
      chk("fl_c3_m_data",  64'(m_data8),  64'(16'h003C));
      step(); #1;
      chk("fl_c4_count",   64'(count8),   64'(0));

      // Reset mid-stream behaves like flush, with s_ready low during reset.
      for (int c = 0; c < 10; c++) begin
         step();
         s_valid8 = 1'b1; s_data8 = 16'(16'h0400 + c); m_ready8 = 1'b1;
      end
      step(); rst_n = 1'b0; #1;
      chk_reset_outputs("mrst1");
      step(); #1;
      chk_reset_outputs("mrst2");
      step();
      rst_n = 1'b1; s_valid8 = 1'b1; s_data8 = 16'h003C; m_ready8 = 1'b1;
      #1;
      chk("mrst_s_ready",   64'(s_ready8), 64'(1));
      chk("mrst_m_valid0",  64'(m_valid8), 64'(0));
      step(); s_valid8 = 1'b0; #1;
      chk("mrst_c1_m_valid", 64'(m_valid8), 64'(0));
      step(); #1;
      chk("mrst_c2_m_valid", 64'(m_valid8), 64'(0));
      step(); #1;
      chk("mrst_c3_m_valid", 64'(m_valid8), 64'(1));
      chk("mrst_c3_m_data",  64'(m_data8),  64'(16'h003C));
      step(); m_ready8 = 1'b0;

      // Wrap on DEPTH=12: 40 words with random backpressure on both sides.
      pushed12 = 0;
      for (int c = 0; c < 400 && popped12 < 40; c++) begin
         step();
         s_valid12 = (pushed12 < 40) && ($urandom_range(0, 3) != 0);
         s_data12  = 16'(16'h5000 + pushed12);
         m_ready12 = ($urandom_range(0, 2) != 0);
         #1;
         if (s_valid12 && s_ready12) pushed12++;
      end
      step(); s_valid12 = 1'b0; m_ready12 = 1'b0; #1;
      chk("wrap_pushed",  64'(pushed12),       64'(40));
      chk("wrap_popped",  64'(popped12),       64'(40));
      chk("wrap_queue",   64'(exp12_q.size()), 64'(0));
      chk("wrap_range",   64'(range_bad12),    64'(0));
      chk("wrap_ab_11_0", 64'(wrap_ab12),      64'(1));
      chk("wrap_aa_11_0", 64'(wrap_aa12),      64'(1));
      chk("wrap_count",   64'(count12),        64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
